// File: rtl/dram_arb_pkg.sv
// ============================================================================
// Module  : dram_arb_pkg
// Brief   : Shared requester IDs, FSM state type and ID helpers for dram_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dram_arb_pkg;

    localparam int NUM_REQ    = 3;
    localparam int ID_W       = 2;

    localparam int REQ_CPU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_UNLOAD = 2;

    localparam logic [ID_W:0] NUM_REQ_V = NUM_REQ[ID_W:0];

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Modulo-NUM_REQ addition of two requester IDs, used for circular search.
    function automatic logic [ID_W-1:0] id_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_REQ_V) begin
            sum = sum - NUM_REQ_V;
        end
        return sum[ID_W-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (id == ID_W'(i));
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// Module  : arb_pick
// Brief   : Combinational one-hot winner picker; circular search from ptr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_pick
    import dram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [ID_W-1:0]    pick_id,
    output logic               pick_any
);

    logic [ID_W-1:0] cand;

    // A zero pointer degenerates to fixed priority 0 > 1 > 2.
    always_comb begin
        pick_oh  = '0;
        pick_id  = '0;
        pick_any = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = id_add(ptr, ID_W'(k));
            if (!pick_any && req[cand]) begin
                pick_any = 1'b1;
                pick_id  = cand;
                pick_oh  = id_onehot(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module  : dram_arbiter
// Brief   : Three-requester DRAM arbiter with lockable grants. Define
//           DRAM_ARB_RR_EN for round-robin; default is fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int              CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t          state;
    logic [ID_W-1:0]     own;
    logic [CNT_W-1:0]    hold_cnt;
    logic [NUM_REQ-1:0]  rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_hold;
    logic [DATA_W-1:0]   wdata_hold;

    logic [ADDR_W-1:0]   addr_sl  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_sl [NUM_REQ];

    logic [NUM_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic [ID_W-1:0]     arb_ptr;

    logic                own_req;
    logic                own_lock;
    logic                own_we;
    logic                access;
    logic                last_access;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
            assign addr_sl[i]  = addr[i*ADDR_W +: ADDR_W];
            assign wdata_sl[i] = wdata[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign own_req     = req[own];
    assign own_lock    = lock[own];
    assign own_we      = we[own];
    assign access      = !rst && (state == ST_OWNED) && own_req && gnt[own];
    assign last_access = !own_lock || (hold_cnt == CNT_LAST);

    assign mem_en    = access;
    assign mem_we    = access && own_we;
    assign mem_addr  = access ? addr_sl[own]  : addr_hold;
    assign mem_wdata = access ? wdata_sl[own] : wdata_hold;

    // DRAM output is already registered; rdata_q keeps it after the strobe.
    // Both are masked during reset so an in-flight read is never reported.
    assign rvalid = rvalid_q & {NUM_REQ{!rst}};
    assign rdata  = rst ? '0 : ((|rvalid_q) ? mem_rdata : rdata_q);

    arb_pick u_pick (
        .req      (req),
        .ptr      (arb_ptr),
        .pick_oh  (pick_oh),
        .pick_id  (pick_id),
        .pick_any (pick_any)
    );

`ifdef DRAM_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            rr_ptr <= id_add(pick_id, ID_W'(1));
        end
    end

    assign arb_ptr = rr_ptr;
`else
    assign arb_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            own        <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            rvalid_q <= (access && !own_we) ? id_onehot(own) : '0;
            if (|rvalid_q) begin
                rdata_q <= mem_rdata;
            end
            if (access) begin
                addr_hold  <= addr_sl[own];
                wdata_hold <= wdata_sl[own];
            end

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_OWNED;
                        own      <= pick_id;
                        gnt      <= pick_oh;
                        hold_cnt <= '0;
                    end
                end
                ST_OWNED: begin
                    // Release always passes through IDLE, giving one dead cycle.
                    if (!own_req || last_access) begin
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
